// File: rtl/bypass_scoreboard.sv
// bypass_scoreboard: keeps in-flight destination records for every issue
// lane across the post-issue pipeline slots, and answers each source query
// of the bundle being issued with hit/ready/forwarded-data. Lane 0 is the
// oldest lane of a bundle, and slot 0 (E) holds the youngest records.
// GPRs, HI (32) and LO (33) share one index space. Index 0 never matches.
module bypass_scoreboard #(
    parameter int ISSUE_W = 2,
    parameter int STAGES  = 3,
    parameter int DATA_W  = 32,
    parameter int IDX_W   = 6
) (
    input  logic                                           clk,
    input  logic                                           reset,
    input  logic                                           stall,
    input  logic                                           flush,
    input  logic [ISSUE_W-1:0]                             issue_valid,
    input  logic [ISSUE_W-1:0]                             issue_wen,
    input  logic [ISSUE_W-1:0][IDX_W-1:0]                  issue_dst,
    input  logic [ISSUE_W-1:0][$clog2(STAGES+1)-1:0]       issue_avail,
    input  logic [STAGES-1:0][ISSUE_W-1:0][DATA_W-1:0]     stage_data,
    input  logic [ISSUE_W-1:0][1:0][IDX_W-1:0]             q_src,
    output logic [ISSUE_W-1:0][1:0]                        q_hit,
    output logic [ISSUE_W-1:0][1:0]                        q_ready,
    output logic [ISSUE_W-1:0][1:0][DATA_W-1:0]            q_data,
    output logic [ISSUE_W-1:0]                             lane_ok,
    output logic [$clog2(STAGES*ISSUE_W+1)-1:0]            inflight_cnt
);

    localparam int AV_W  = $clog2(STAGES + 1);
    localparam int CNT_W = $clog2(STAGES * ISSUE_W + 1);

    // Record storage, indexed [slot][lane].
    logic [STAGES-1:0][ISSUE_W-1:0]            valid_q, valid_d;
    logic [STAGES-1:0][ISSUE_W-1:0][IDX_W-1:0] dst_q, dst_d;
    logic [STAGES-1:0][ISSUE_W-1:0][AV_W-1:0]  avail_q, avail_d;
    logic [CNT_W-1:0]                          cnt_q, cnt_d;

    // Query scratch.
    logic [IDX_W-1:0] src;
    logic             found;

    // Next record state: flush beats stall, stall holds, otherwise shift and load slot 0.
    always_comb begin
        valid_d = valid_q;
        dst_d   = dst_q;
        avail_d = avail_q;
        if (flush) begin
            valid_d = '0;
        end else if (!stall) begin
            for (int s = STAGES - 1; s > 0; s--) begin
                valid_d[s] = valid_q[s-1];
                dst_d[s]   = dst_q[s-1];
                avail_d[s] = avail_q[s-1];
            end
            for (int l = 0; l < ISSUE_W; l++) begin
                valid_d[0][l] = issue_valid[l] & issue_wen[l] & (issue_dst[l] != '0);
                dst_d[0][l]   = issue_dst[l];
                avail_d[0][l] = issue_avail[l];
            end
        end
        cnt_d = '0;
        for (int s = 0; s < STAGES; s++) begin
            for (int l = 0; l < ISSUE_W; l++) begin
                cnt_d = cnt_d + CNT_W'(valid_d[s][l]);
            end
        end
    end

    // Record and counter registers; the counter tracks the popcount of the new valid bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            dst_q   <= '0;
            avail_q <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            dst_q   <= dst_d;
            avail_q <= avail_d;
            cnt_q   <= cnt_d;
        end
    end

    assign inflight_cnt = cnt_q;

    // Source lookup: an older lane of the same bundle wins, then the youngest record.
    // Only the first match found is used, so an older ready record never
    // overrides a younger one that is not yet forwardable.
    always_comb begin
        q_hit   = '0;
        q_ready = '1;
        q_data  = '0;
        src     = '0;
        found   = 1'b0;
        for (int j = 0; j < ISSUE_W; j++) begin
            for (int x = 0; x < 2; x++) begin
                src   = q_src[j][x];
                found = 1'b0;
                if (src != '0) begin
                    for (int i = 0; i < j; i++) begin
                        if (!found && issue_valid[i] && issue_wen[i] && issue_dst[i] == src) begin
                            found         = 1'b1;
                            q_hit[j][x]   = 1'b1;
                            q_ready[j][x] = 1'b0;
                        end
                    end
                    for (int s = 0; s < STAGES; s++) begin
                        for (int l = ISSUE_W - 1; l >= 0; l--) begin
                            if (!found && valid_q[s][l] && dst_q[s][l] == src) begin
                                found       = 1'b1;
                                q_hit[j][x] = 1'b1;
                                if (int'(avail_q[s][l]) <= s) begin
                                    q_ready[j][x] = 1'b1;
                                    q_data[j][x]  = stage_data[s][l];
                                end else begin
                                    q_ready[j][x] = 1'b0;
                                end
                            end
                        end
                    end
                end
            end
        end
    end

    // A lane may issue only when both of its sources are usable.
    always_comb begin
        lane_ok = '0;
        for (int j = 0; j < ISSUE_W; j++) begin
            lane_ok[j] = &q_ready[j];
        end
    end

endmodule
